// File: rtl/disp_pkg.sv
// Shared types for the display register-file write path.
package disp_pkg;
  localparam int DISP_ADDR_W = 8;
  localparam int DISP_DATA_W = 8;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  typedef struct packed {
    logic [DISP_ADDR_W-1:0] addr;
    logic [DISP_DATA_W-1:0] data;
  } disp_wr_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or above ptr_i, with wrap.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   grant_o,
  output logic            any_o
);
  int idx;

  // Scan from farthest to nearest so the nearest valid requester is the final writer.
  always_comb begin
    grant_o = ptr_i;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (valid_i[idx]) begin
        grant_o = IW'(idx);
        any_o   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/disp_wr_arb.sv
// Round-robin arbiter for the display register file's single write port,
// granting bounded multi-beat bursts with a registered write output.
module disp_wr_arb
  import disp_pkg::*;
#(
  parameter  int NREQ      = 2,
  parameter  int MAX_BURST = 8,
  localparam int IW        = $clog2(NREQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ-1:0]                   req_last,
  input  logic [NREQ-1:0][DISP_ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][DISP_DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]                   req_ready,
  output logic                              load,
  output logic [DISP_ADDR_W-1:0]            addr,
  output logic [DISP_DATA_W-1:0]            data,
  output logic                              busy,
  output logic [IW-1:0]                     owner
);
  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          load_q, load_d;
  disp_wr_t      wr_q, wr_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          accept;
  logic [IW-1:0] ptr_after_owner;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  assign accept          = (state_q == BURST) && req_valid[owner_q];
  assign ptr_after_owner = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    load_d     = 1'b0;
    wr_d       = wr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // An owner stall simply holds the grant; there is no timeout.
        if (accept) begin
          load_d     = 1'b1;
          wr_d.addr  = req_addr[owner_q];
          wr_d.data  = req_data[owner_q];
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (req_last[owner_q] || beat_cnt_d == CW'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_after_owner;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      load_q     <= 1'b0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      load_q     <= load_d;
      wr_q       <= wr_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == BURST) req_ready[owner_q] = 1'b1;
  end

  assign load  = load_q;
  assign addr  = wr_q.addr;
  assign data  = wr_q.data;
  assign busy  = (state_q == BURST);
  assign owner = owner_q;
endmodule

// File: doc/disp_wr_arb.md
# disp_wr_arb

Round-robin arbiter sharing the display register file's single write port (`load`/`addr`/`data`) between several requesters, e.g. the SPI flash loader and on-chip status writers. Each requester presents beats through a valid/ready handshake and may hold the port for a multi-beat burst, bounded by a maximum burst length. The block sits between the requesters and `vga_driver`'s write port, in the `clk` domain.

## Interface

Parameters:
- `NREQ`, 2, number of requesters (2..8).
- `MAX_BURST`, 8, beats one requester may hold the port before forced release (1..256).

Ports:
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid` in [NREQ]: requester i has a beat.
- `req_last` in [NREQ]: the beat is the final beat of the burst.
- `req_addr` in [NREQ][8]: target register index.
- `req_data` in [NREQ][8]: write data.
- `req_ready` out [NREQ]: beat accepted this cycle when valid and ready are both high.
- `load` out 1: write strobe to display memory.
- `addr` out 8: write index.
- `data` out 8: write data.
- `busy` out 1: a grant is held (state is BURST).
- `owner` out $clog2(NREQ): index of the current or last grantee.

## Operation

- States: IDLE and BURST.
- IDLE:
  - If any `req_valid` is high, pick the first requester at or after `rr_ptr`, searching upward with wrap.
  - Set `owner`, clear `beat_cnt`, go to BURST.
  - `req_ready` is all-zero in IDLE.
- BURST:
  - `req_ready[owner]` = 1; all other ready bits are 0. Ready is decoded from the state register.
  - On an accepted beat, latch addr/data into the output registers, pulse `load`, and increment `beat_cnt`.
  - If the owner drops `req_valid`, the grant is held and no beat is accepted. There is no timeout.
  - Exit to IDLE on an accepted beat that either has `req_last`=1 or brings `beat_cnt` to `MAX_BURST` (forced release).
  - On exit, `rr_ptr` <= (owner+1) mod NREQ.
  - After a forced release, the requester's remaining beats re-arbitrate like a new burst.
- Non-owner valid requests wait, with their inputs held stable by the requester.
- `beat_cnt` is $clog2(MAX_BURST+1) bits wide and never wraps.
- `addr` is passed through unchecked. Indices ≥8 are the consumer's concern.

## Timing

- Reset values:
  - State IDLE, `rr_ptr`=0, `owner`=0, `beat_cnt`=0.
  - `load`=0, `addr`=0, `data`=0, `busy`=0, `req_ready`=0.
- Arbitration takes 1 cycle. A valid in IDLE at edge N gives BURST and ready at N+1.
- The write output has 1-cycle latency. A beat accepted at edge N drives `load`=1 with its `addr`/`data` during the cycle after N.
- `load` is high for exactly one cycle per accepted beat. Throughput is 1 beat/cycle within a burst.
- Between bursts there is 1 dead cycle (IDLE). A new grant cannot be issued on the same edge as a release.
- If several requesters are valid in IDLE, the one nearest at or above `rr_ptr` wins.
- A single-beat burst (`req_last` on the first beat) still costs the IDLE cycle.
- `MAX_BURST`=1 forces release after every beat.
- Reset asserted mid-burst:
  - All outputs go to reset values immediately; any in-flight `load` is dropped.
  - Partially transferred bursts are not resumed. The requester restarts after reset.

## Structure

- Package `disp_pkg` holds:
  - `DISP_ADDR_W`=8, `DISP_DATA_W`=8.
  - The `arb_state_e` enum {IDLE, BURST}.
  - The write-beat struct `disp_wr_t` {addr, data}, shared with the SPI loader.
- Sub-module `rr_pick`: combinational, parameterised on NREQ. Inputs are the valid vector and pointer; outputs are the grant index and an any-valid flag. Unit-testable alone.
- The top level contains the state register, counter, pointer and output registers only.

## Test plan

- **Reset:** hold `n_rst`=0 with `req_valid`=2'b11. Expect `load`=0, `req_ready`=0, `busy`=0, `owner`=0. Release reset: requester 0 is granted 1 cycle later.
- **Single burst:** requester 1 sends 3 beats (addr 0,1,2; data 8'hA0,8'hA1,8'hA2; last on the third). Expect 3 consecutive `load` pulses starting 2 cycles after valid, then `busy`=0 and `rr_ptr`=0.
- **Round-robin:** both requesters continuously send 1-beat bursts. Grants alternate 0,1,0,1, and each pulse is followed by a dead cycle.
- **Forced release:** `MAX_BURST`=4; requester 0 sends 6 beats with last on the sixth while requester 1 is valid. Expect 4 beats from 0, then 1's burst, then 0's remaining 2 beats.
- **Stall:** the owner drops valid for 3 cycles mid-burst while the other requester is valid. Expect no `load`, the grant held, and the burst to resume.
- **Mid-burst reset:** assert `n_rst` after beat 2 of 5. Expect outputs at reset values the same cycle, and no further `load` until a new arbitration.
